// File: rtl/nn_pkg.sv
// Shared helpers for the NN datapath blocks.
// - clog2 / idx_width / num_beats: elaboration-time sizing helpers.
// - gt_cmp: strict greater-than on operands already widened to CmpWidth
//   (callers sign- or zero-extend so one compare serves both modes).
// - argmax_state_e: FSM state encoding for argmax_stream.
package nn_pkg;

    // Scores up to this width are supported by gt_cmp.
    localparam int unsigned CmpWidth = 64;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } argmax_state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned v;
        int unsigned r;
        r = 0;
        if (n > 1) begin
            v = n - 1;
            while (v > 0) begin
                v = v >> 1;
                r++;
            end
        end
        return r;
    endfunction

    // Index width that is never zero, even for a single element.
    function automatic int unsigned idx_width(input int unsigned n);
        return (clog2(n) == 0) ? 1 : clog2(n);
    endfunction

    function automatic int unsigned num_beats(input int unsigned n, input int unsigned lanes);
        return (n + lanes - 1) / lanes;
    endfunction

    function automatic logic gt_cmp(input logic [CmpWidth-1:0] a,
                                    input logic [CmpWidth-1:0] b,
                                    input bit                  signed_mode);
        if (signed_mode) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

endpackage

// File: rtl/argmax_lane_tree.sv
// Combinational local-max selector for one beat of LANES scores.
// Ports:
//   data_i     LANES*DATA_WIDTH  beat payload, lane 0 in the LSBs
//   lane_en_i  LANES             lanes allowed to compete
//   max_val_o  DATA_WIDTH        largest enabled score
//   max_lane_o LANE_IDX_WIDTH    lane of that score (lowest lane on ties)
module argmax_lane_tree
    import nn_pkg::*;
#(
    parameter int unsigned  DATA_WIDTH     = 16,
    parameter int unsigned  LANES          = 5,
    parameter bit           SIGNED         = 1'b1,
    localparam int unsigned LANE_IDX_WIDTH = idx_width(LANES)
) (
    input  logic [LANES*DATA_WIDTH-1:0] data_i,
    input  logic [LANES-1:0]            lane_en_i,
    output logic [DATA_WIDTH-1:0]       max_val_o,
    output logic [LANE_IDX_WIDTH-1:0]   max_lane_o
);

    function automatic logic [CmpWidth-1:0] widen(input logic [DATA_WIDTH-1:0] x);
        if (SIGNED) begin
            return CmpWidth'($signed(x));
        end
        return CmpWidth'(x);
    endfunction

    // Priority scan: a later lane only wins when strictly greater, so ties
    // keep the lower lane.
    always_comb begin : p_scan
        logic                  found;
        logic [DATA_WIDTH-1:0] cand;
        found      = 1'b0;
        cand       = '0;
        max_val_o  = '0;
        max_lane_o = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            cand = data_i[i*DATA_WIDTH +: DATA_WIDTH];
            if (lane_en_i[i] && (!found || gt_cmp(widen(cand), widen(max_val_o), SIGNED))) begin
                max_val_o  = cand;
                max_lane_o = LANE_IDX_WIDTH'(i);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax: finds the largest of INPUT_NUM scores delivered as beats
// of LANES elements and returns the value and its global index.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   data_in         beat payload, lane 0 in the LSBs
//   data_valid      beat present; accepted when data_ready is also 1
//   data_ready      !output_valid || output_ready
//   flush           drops a partial vector (ignored once the result is done)
//   output_data     maximum value, meaningful while output_valid
//   output_index    global index of the maximum (lowest index on ties)
//   output_valid    result present; consumed when output_ready is also 1
//   output_ready    result sink ready
module argmax_stream
    import nn_pkg::*;
#(
    parameter int unsigned  DATA_WIDTH = 16,
    parameter int unsigned  INPUT_NUM  = 10,
    parameter int unsigned  LANES      = 5,
    parameter bit           SIGNED     = 1'b1,
    localparam int unsigned NUM_BEATS  = num_beats(INPUT_NUM, LANES),
    localparam int unsigned IDX_WIDTH  = idx_width(INPUT_NUM)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [LANES*DATA_WIDTH-1:0] data_in,
    input  logic                        data_valid,
    output logic                        data_ready,
    input  logic                        flush,
    output logic [DATA_WIDTH-1:0]       output_data,
    output logic [IDX_WIDTH-1:0]        output_index,
    output logic                        output_valid,
    input  logic                        output_ready
);

    localparam int unsigned LaneIdxWidth = idx_width(LANES);
    localparam int unsigned BeatCntWidth = idx_width(NUM_BEATS);

    argmax_state_e             state_q, state_d;
    logic [BeatCntWidth-1:0]   beat_cnt_q, beat_cnt_d;
    logic [DATA_WIDTH-1:0]     run_val_q, run_val_d;
    logic [IDX_WIDTH-1:0]      run_idx_q, run_idx_d;
    logic [DATA_WIDTH-1:0]     out_val_q, out_val_d;
    logic [IDX_WIDTH-1:0]      out_idx_q, out_idx_d;

    logic [31:0]               beat_base;
    logic [LANES-1:0]          lane_en;
    logic [DATA_WIDTH-1:0]     local_val;
    logic [LaneIdxWidth-1:0]   local_lane;
    logic [IDX_WIDTH-1:0]      local_idx;
    logic                      local_gt;
    logic [DATA_WIDTH-1:0]     merged_val;
    logic [IDX_WIDTH-1:0]      merged_idx;
    logic                      accept;

    function automatic logic [CmpWidth-1:0] widen(input logic [DATA_WIDTH-1:0] x);
        if (SIGNED) begin
            return CmpWidth'($signed(x));
        end
        return CmpWidth'(x);
    endfunction

    // beat_cnt_q is zero outside ACCUM, so a first beat always starts at index 0.
    assign beat_base = 32'(beat_cnt_q) * 32'(LANES);

    // Masks lanes past the end of the vector on a partial last beat.
    always_comb begin
        lane_en = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_en[i] = (beat_base + 32'(i)) < 32'(INPUT_NUM);
        end
    end

    argmax_lane_tree #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .SIGNED     (SIGNED)
    ) u_lane_tree (
        .data_i     (data_in),
        .lane_en_i  (lane_en),
        .max_val_o  (local_val),
        .max_lane_o (local_lane)
    );

    assign local_idx  = IDX_WIDTH'(beat_base + 32'(local_lane));
    // Strictly greater only: an equal later score keeps the earlier index.
    assign local_gt   = gt_cmp(widen(local_val), widen(run_val_q), SIGNED);
    assign merged_val = local_gt ? local_val : run_val_q;
    assign merged_idx = local_gt ? local_idx : run_idx_q;
    assign accept     = data_valid && data_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
            run_val_q  <= '0;
            run_idx_q  <= '0;
            out_val_q  <= '0;
            out_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            run_val_q  <= run_val_d;
            run_idx_q  <= run_idx_d;
            out_val_q  <= out_val_d;
            out_idx_q  <= out_idx_d;
        end
    end

    always_comb begin : p_next
        logic start;
        start      = 1'b0;
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        run_val_d  = run_val_q;
        run_idx_d  = run_idx_q;
        out_val_d  = out_val_q;
        out_idx_d  = out_idx_q;

        unique case (state_q)
            StIdle: begin
                if (accept && !flush) begin
                    start = 1'b1;
                end
            end
            StAccum: begin
                if (flush) begin
                    state_d    = StIdle;
                    beat_cnt_d = '0;
                end else if (accept) begin
                    run_val_d = merged_val;
                    run_idx_d = merged_idx;
                    if (beat_cnt_q == BeatCntWidth'(NUM_BEATS - 1)) begin
                        state_d    = StDone;
                        beat_cnt_d = '0;
                        out_val_d  = merged_val;
                        out_idx_d  = merged_idx;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                // Result pops; a first beat in the same cycle starts the next vector.
                if (output_ready) begin
                    state_d = StIdle;
                    start   = accept;
                end
            end
            default: begin
                state_d    = StIdle;
                beat_cnt_d = '0;
            end
        endcase

        if (start) begin
            run_val_d = local_val;
            run_idx_d = local_idx;
            if (NUM_BEATS == 1) begin
                state_d   = StDone;
                out_val_d = local_val;
                out_idx_d = local_idx;
            end else begin
                state_d    = StAccum;
                beat_cnt_d = BeatCntWidth'(1);
            end
        end
    end

    always_comb begin
        output_valid = (state_q == StDone);
        data_ready   = !output_valid || output_ready;
        output_data  = out_val_q;
        output_index = out_idx_q;
    end

endmodule

// File: tb/tb_argmax_stream.sv
// Directed bench for argmax_stream. Three instances share one stimulus:
// defaults (s_*), unsigned compare (u_*), and INPUT_NUM=7 (n_*).
module tb_argmax_stream;

    logic        clk;
    logic        rst_n;
    logic [79:0] data_in;
    logic        data_valid;
    logic        flush;
    logic        output_ready;

    logic        s_ready, s_valid, u_ready, u_valid, n_ready, n_valid;
    logic [15:0] s_data, u_data, n_data;
    logic [3:0]  s_index, u_index;
    logic [2:0]  n_index;

    logic [15:0] vec [10];
    int          nvec;
    int          nerr;

    argmax_stream u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (s_ready),
        .flush        (flush),
        .output_data  (s_data),
        .output_index (s_index),
        .output_valid (s_valid),
        .output_ready (output_ready)
    );

    argmax_stream #(
        .SIGNED (1'b0)
    ) u_uns (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (u_ready),
        .flush        (flush),
        .output_data  (u_data),
        .output_index (u_index),
        .output_valid (u_valid),
        .output_ready (output_ready)
    );

    argmax_stream #(
        .INPUT_NUM (7),
        .LANES     (5)
    ) u_n7 (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (n_ready),
        .flush        (flush),
        .output_data  (n_data),
        .output_index (n_index),
        .output_valid (n_valid),
        .output_ready (output_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 10; i++) vec[i] = v;
    endtask

    task automatic drive_beat(input int b);
        data_in    = {vec[b*5+4], vec[b*5+3], vec[b*5+2], vec[b*5+1], vec[b*5]};
        data_valid = 1'b1;
    endtask

    // Two beats back to back; result must appear on the edge after beat 2.
    task automatic run_vec();
        drive_beat(0);
        step();
        chk("lat_after_beat1", 32'(s_valid), 32'd0);
        drive_beat(1);
        step();
        data_valid = 1'b0;
    endtask

    initial begin
        nvec         = 0;
        nerr         = 0;
        rst_n        = 1'b1;
        data_in      = '0;
        data_valid   = 1'b0;
        flush        = 1'b0;
        output_ready = 1'b1;
        fill(16'h0);

        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_data",  32'(s_data),  32'd0);
        chk("rst_index", 32'(s_index), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd1);
        step();
        step();
        rst_n = 1'b1;

        // One-hot sweep across both beats.
        for (int p = 0; p < 10; p++) begin
            fill(16'h0);
            vec[p] = 16'h0001;
            run_vec();
            chk("sweep_valid", 32'(s_valid), 32'd1);
            chk("sweep_index", 32'(s_index), 32'(p));
            chk("sweep_data",  32'(s_data),  32'd1);
            step();
            chk("sweep_pop",   32'(s_valid), 32'd0);
        end

        // All negative: -100 everywhere, -3 at index 7.
        fill(16'hFF9C);
        vec[7] = 16'hFFFD;
        run_vec();
        chk("neg_s_index", 32'(s_index), 32'd7);
        chk("neg_s_data",  32'(s_data),  32'h0000FFFD);
        chk("neg_u_index", 32'(u_index), 32'd7);
        chk("neg_u_data",  32'(u_data),  32'h0000FFFD);
        step();

        // Add +5 at index 4: signed picks 5, unsigned picks the 0xFFFD pattern.
        vec[4] = 16'h0005;
        run_vec();
        chk("mix_s_index", 32'(s_index), 32'd4);
        chk("mix_s_data",  32'(s_data),  32'd5);
        chk("mix_u_index", 32'(u_index), 32'd7);
        chk("mix_u_data",  32'(u_data),  32'h0000FFFD);
        step();

        // Ties at 2, 6, 9 resolve to the lowest index.
        fill(16'h0);
        vec[2] = 16'd5;
        vec[6] = 16'd5;
        vec[9] = 16'd5;
        run_vec();
        chk("tie_s_index", 32'(s_index), 32'd2);
        chk("tie_s_data",  32'(s_data),  32'd5);
        chk("tie_u_index", 32'(u_index), 32'd2);
        step();

        // INPUT_NUM=7: indices 7..9 are out of range for u_n7.
        fill(16'h0);
        vec[3] = 16'd9;
        vec[5] = 16'd1;
        vec[6] = 16'd2;
        vec[7] = 16'h7FFF;
        vec[8] = 16'h7FFF;
        vec[9] = 16'h7FFF;
        run_vec();
        chk("n7_valid", 32'(n_valid), 32'd1);
        chk("n7_index", 32'(n_index), 32'd3);
        chk("n7_data",  32'(n_data),  32'd9);
        chk("n10_index", 32'(s_index), 32'd7);
        chk("n10_data",  32'(s_data),  32'h00007FFF);
        step();

        // Backpressure: result held 10 cycles while the next first beat waits.
        output_ready = 1'b0;
        fill(16'h0);
        vec[1] = 16'd50;
        run_vec();
        fill(16'h0);
        vec[3] = 16'd20;
        vec[8] = 16'd30;
        drive_beat(0);
        for (int k = 0; k < 10; k++) begin
            chk("stall_ready", 32'(s_ready), 32'd0);
            chk("stall_valid", 32'(s_valid), 32'd1);
            chk("stall_index", 32'(s_index), 32'd1);
            chk("stall_data",  32'(s_data),  32'd50);
            step();
        end
        output_ready = 1'b1;
        step();
        chk("overlap_pop", 32'(s_valid), 32'd0);
        drive_beat(1);
        step();
        data_valid = 1'b0;
        chk("overlap_valid", 32'(s_valid), 32'd1);
        chk("overlap_index", 32'(s_index), 32'd8);
        chk("overlap_data",  32'(s_data),  32'd30);
        step();

        // Flush while DONE is ignored.
        output_ready = 1'b0;
        fill(16'h0);
        vec[9] = 16'd11;
        run_vec();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("done_flush_valid", 32'(s_valid), 32'd1);
        chk("done_flush_index", 32'(s_index), 32'd9);
        chk("done_flush_data",  32'(s_data),  32'd11);
        output_ready = 1'b1;
        step();
        chk("done_flush_pop", 32'(s_valid), 32'd0);

        // Flush after beat 1; the beat presented with flush is dropped.
        fill(16'h0);
        vec[1] = 16'd100;
        drive_beat(0);
        step();
        data_in    = {16'd0, 16'd0, 16'd0, 16'd0, 16'd200};
        data_valid = 1'b1;
        flush      = 1'b1;
        step();
        flush      = 1'b0;
        data_valid = 1'b0;
        chk("flush_valid", 32'(s_valid), 32'd0);
        step();
        chk("flush_idle", 32'(s_valid), 32'd0);
        fill(16'h0);
        vec[4] = 16'd7;
        vec[5] = 16'd3;
        run_vec();
        chk("post_flush_index", 32'(s_index), 32'd4);
        chk("post_flush_data",  32'(s_data),  32'd7);
        step();

        // Asynchronous reset mid-vector clears outputs without a clock edge.
        fill(16'h0);
        vec[2] = 16'd40;
        drive_beat(0);
        step();
        data_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(s_valid), 32'd0);
        chk("arst_data",  32'(s_data),  32'd0);
        chk("arst_index", 32'(s_index), 32'd0);
        chk("arst_ready", 32'(s_ready), 32'd1);
        step();
        rst_n = 1'b1;
        fill(16'h0);
        vec[0] = 16'd3;
        vec[6] = 16'd12;
        run_vec();
        chk("post_rst_valid", 32'(s_valid), 32'd1);
        chk("post_rst_index", 32'(s_index), 32'd6);
        chk("post_rst_data",  32'(s_data),  32'd12);
        step();
        chk("post_rst_pop", 32'(s_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
